// File: rtl/cp0_pkg.sv
// cp0_pkg: register indices, ExcCodes and the handler vector for the
// coprocessor-0 block. Shared by cp0, cp0_timer and the bench.
package cp0_pkg;

  // Default processor-ID value returned by register 15
  localparam logic [31:0] PRID_DEFAULT = 32'h0000_7C01;

  // Register indices
  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;

  // ExcCode values the pipeline can raise
  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exccode_e;

  // Fetch redirects here whenever take is asserted
  localparam logic [31:0] HANDLER_VEC = 32'h0000_4180;

  // Word address recorded in EPC: a delay-slot victim restarts at its branch.
  // Subtracting one word from pc[31:2] equals {pc[31:2],2'b00}-4 modulo 2^32.
  function automatic logic [29:0] victim_word(input logic [31:0] pc, input logic bd);
    return bd ? (pc[31:2] - 30'd1) : pc[31:2];
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare pair with a sticky match flag feeding IP[15].
// Only instantiated when CP0_TIMER_EN is defined.
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        we_count,
  input  logic        we_compare,
  input  logic [31:0] din,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        pending
);

  logic [31:0] count_reg;
  logic [31:0] compare_reg;
  logic        pending_reg;

  // Count free-runs and wraps; an mtc0 to Count loads it instead of incrementing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (we_count) begin
      count_reg <= din;
    end else begin
      count_reg <= count_reg + 32'd1;
    end
  end

  // Compare only changes under software control
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      compare_reg <= 32'hFFFF_FFFF;
    end else if (we_compare) begin
      compare_reg <= din;
    end
  end

  // Match is sticky until software rewrites Compare (the usual acknowledge)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_reg <= 1'b0;
    end else if (we_compare) begin
      pending_reg <= 1'b0;
    end else if (count_reg == compare_reg) begin
      pending_reg <= 1'b1;
    end
  end

  assign count   = count_reg;
  assign compare = compare_reg;
  assign pending = pending_reg;

endmodule

// File: rtl/cp0.sv
// cp0: coprocessor-0 register file (SR, Cause, EPC, PRId) and the
// exception/interrupt arbiter beside the M stage.
// Optional feature macro: CP0_TIMER_EN adds Count(9)/Compare(11) via cp0_timer.
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = PRID_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  a1,
  input  logic [4:0]  a2,
  input  logic [31:0] din,
  input  logic        we,
  input  logic [31:0] pc,
  input  logic        bd,
  input  logic        exc_valid,
  input  logic [4:0]  exccode,
  input  logic        exl_clr,
  input  logic [5:0]  hwint,
  output logic [31:0] dout,
  output logic [31:0] epc,
  output logic        int_req,
  output logic        take
);

  // Architectural state
  logic [5:0]  sr_im_reg;
  logic        sr_exl_reg;
  logic        sr_ie_reg;
  logic        cause_bd_reg;
  logic [5:0]  cause_ip_reg;
  logic [4:0]  cause_exc_reg;
  logic [29:0] epc_reg;

  logic [5:0]  ip;          // visible IP field, including timer contribution
  logic [5:0]  ip_masked;
  logic        timer_pend;
  logic        sw_we;       // mtc0 that actually commits (not flushed by take)

  assign sw_we = we & ~take;

`ifdef CP0_TIMER_EN
  logic [31:0] timer_count;
  logic [31:0] timer_compare;

  cp0_timer u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .we_count   (sw_we && (a2 == CP0_COUNT)),
    .we_compare (sw_we && (a2 == CP0_COMPARE)),
    .din        (din),
    .count      (timer_count),
    .compare    (timer_compare),
    .pending    (timer_pend)
  );
`else
  assign timer_pend = 1'b0;
`endif

  assign ip = {cause_ip_reg[5] | timer_pend, cause_ip_reg[4:0]};

  // Per-line masking of pending interrupts by SR.IM
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_mask
      assign ip_masked[gi] = ip[gi] & sr_im_reg[gi];
    end
  endgenerate

  assign int_req = (|ip_masked) & sr_ie_reg & ~sr_exl_reg;
  assign take    = int_req | (exc_valid & ~sr_exl_reg);
  assign epc     = {epc_reg, 2'b00};

  // Hardware interrupt lines are sampled every cycle regardless of EXL
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cause_ip_reg <= '0;
    end else begin
      cause_ip_reg <= hwint;
    end
  end

  // Exception entry records the victim; Cause is otherwise read-only
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cause_bd_reg  <= 1'b0;
      cause_exc_reg <= '0;
    end else if (take) begin
      cause_bd_reg  <= bd;
      cause_exc_reg <= int_req ? EXC_INT : exccode;
    end
  end

  // EPC: exception entry beats an mtc0 in the same cycle (that mtc0 is flushed)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      epc_reg <= '0;
    end else if (take) begin
      epc_reg <= victim_word(pc, bd);
    end else if (sw_we && (a2 == CP0_EPC)) begin
      epc_reg <= din[31:2];
    end
  end

  // SR: take sets EXL and overrides both mtc0 and eret; an explicit mtc0
  // to SR wins over a coincident eret since it names the new value directly
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_im_reg  <= '0;
      sr_exl_reg <= 1'b0;
      sr_ie_reg  <= 1'b0;
    end else if (take) begin
      sr_exl_reg <= 1'b1;
    end else if (sw_we && (a2 == CP0_SR)) begin
      sr_im_reg  <= din[15:10];
      sr_exl_reg <= din[1];
      sr_ie_reg  <= din[0];
    end else if (exl_clr) begin
      sr_exl_reg <= 1'b0;
    end
  end

  // mfc0 read mux; unlisted indices and bits read 0
  always_comb begin
    dout = '0;
    case (a1)
      CP0_SR:      dout = {16'd0, sr_im_reg, 8'd0, sr_exl_reg, sr_ie_reg};
      CP0_CAUSE:   dout = {cause_bd_reg, 15'd0, ip, 3'd0, cause_exc_reg, 2'b00};
      CP0_EPC:     dout = {epc_reg, 2'b00};
      CP0_PRID:    dout = PRID;
`ifdef CP0_TIMER_EN
      CP0_COUNT:   dout = timer_count;
      CP0_COMPARE: dout = timer_compare;
`endif
      default:     dout = '0;
    endcase
  end

  // Low PC bits never reach EPC (word-aligned victims)
  logic unused_pc_bits;
  assign unused_pc_bits = ^pc[1:0];

endmodule

// File: tb/tb_cp0.sv
// tb_cp0: directed scoreboard bench for cp0. Stimulus pushes expected
// observations; a negedge monitor pops and compares them.
module tb_cp0;
  import cp0_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  a1, a2, exccode;
  logic [31:0] din, pc;
  logic        we, bd, exc_valid, exl_clr;
  logic [5:0]  hwint;
  logic [31:0] dout, epc;
  logic        int_req, take;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    int          sel;   // 0 dout, 1 epc, 2 int_req, 3 take
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];

  cp0 dut (
    .clk(clk), .reset_n(reset_n), .a1(a1), .a2(a2), .din(din), .we(we),
    .pc(pc), .bd(bd), .exc_valid(exc_valid), .exccode(exccode),
    .exl_clr(exl_clr), .hwint(hwint), .dout(dout), .epc(epc),
    .int_req(int_req), .take(take)
  );

  always #5 clk = ~clk;

  // Monitor: compares every queued expectation at the falling edge
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = sb_q.pop_front();
      case (e.sel)
        0: act = dout;
        1: act = epc;
        2: act = {31'd0, int_req};
        default: act = {31'd0, take};
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
      end else begin
        $display("ok   %s: 0x%08h", e.name, act);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_sig(input string name, input int sel, input logic [31:0] exp);
    exp_t e;
    e.name = name; e.sel = sel; e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Reads one register via a1 this cycle, then advances a cycle
  task automatic read_reg(input string name, input logic [4:0] idx, input logic [31:0] exp);
    a1 = idx;
    expect_sig(name, 0, exp);
    tick();
  endtask

  task automatic mtc0(input logic [4:0] idx, input logic [31:0] data);
    we = 1'b1; a2 = idx; din = data;
    tick();
    we = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; a1 = '0; a2 = '0; din = '0; we = 1'b0; pc = '0; bd = 1'b0;
    exc_valid = 1'b0; exccode = '0; exl_clr = 1'b0; hwint = '0;
    tick(); tick();
    read_reg("reset_sr", CP0_SR, 32'h0);
    a1 = CP0_PRID;
    expect_sig("reset_prid", 0, 32'h0000_7C01);
    expect_sig("reset_epc", 1, 32'h0);
    expect_sig("reset_int_req", 2, 32'h0);
    expect_sig("reset_take", 3, 32'h0);
    tick();
    reset_n = 1'b1;
    tick();

    // Interrupt path
    mtc0(CP0_SR, 32'h0000_0401);
    hwint = 6'b000001; pc = 32'h0000_3008;
    a1 = CP0_SR;
    expect_sig("sr_after_mtc0", 0, 32'h0000_0401);
    expect_sig("int_req_latency", 2, 32'h0);
    tick();
    expect_sig("int_req_rise", 2, 32'h1);
    expect_sig("int_take_rise", 3, 32'h1);
    tick();
    hwint = 6'b0;
    expect_sig("int_epc", 1, 32'h0000_3008);
    expect_sig("int_req_fall", 2, 32'h0);
    read_reg("int_sr_exl", CP0_SR, 32'h0000_0403);

    // Exception masked while EXL=1, then eret
    exc_valid = 1'b1; exccode = EXC_ADEL; pc = 32'h0000_4000;
    expect_sig("exl_blocks_take", 3, 32'h0);
    tick();
    exc_valid = 1'b0;
    exl_clr = 1'b1;
    expect_sig("exl_epc_hold", 1, 32'h0000_3008);
    tick();
    exl_clr = 1'b0;
    expect_sig("eret_epc_hold", 1, 32'h0000_3008);
    read_reg("eret_sr", CP0_SR, 32'h0000_0401);

    // Synchronous exception in a delay slot
    exc_valid = 1'b1; exccode = EXC_OV; bd = 1'b1; pc = 32'h0000_3010;
    expect_sig("exc_take", 3, 32'h1);
    tick();
    exc_valid = 1'b0; bd = 1'b0;
    expect_sig("exc_epc_bd", 1, 32'h0000_300C);
    read_reg("exc_cause", CP0_CAUSE, 32'h8000_0030);
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;

    // take beats a coincident mtc0 and a coincident eret
    hwint = 6'b000001;
    tick();
    we = 1'b1; a2 = CP0_EPC; din = 32'h0000_5000; exl_clr = 1'b1; pc = 32'h0000_3100;
    expect_sig("collide_take", 3, 32'h1);
    tick();
    we = 1'b0; exl_clr = 1'b0; hwint = 6'b0;
    expect_sig("collide_epc", 1, 32'h0000_3100);
    read_reg("collide_sr_exl", CP0_SR, 32'h0000_0403);
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;

    // EPC wrap-around at pc=0 in a delay slot
    exc_valid = 1'b1; exccode = EXC_RI; bd = 1'b1; pc = 32'h0;
    tick();
    exc_valid = 1'b0; bd = 1'b0;
    expect_sig("wrap_epc", 1, 32'hFFFF_FFFC);
    read_reg("wrap_cause", CP0_CAUSE, 32'h8000_0028);
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;

    // Software writes: EPC low bits dropped, Cause and PRId read-only
    mtc0(CP0_EPC, 32'h0000_5003);
    expect_sig("mtc0_epc", 1, 32'h0000_5000);
    mtc0(CP0_CAUSE, 32'hFFFF_FFFF);
    read_reg("cause_ro", CP0_CAUSE, 32'h8000_0028);
    mtc0(CP0_PRID, 32'h1234_5678);
    read_reg("prid_ro", CP0_PRID, 32'h0000_7C01);
    read_reg("unlisted_idx", 5'd5, 32'h0);

`ifndef CP0_TIMER_EN
    mtc0(CP0_COUNT, 32'd123);
    read_reg("no_count", CP0_COUNT, 32'h0);
    mtc0(CP0_COMPARE, 32'd55);
    read_reg("no_compare", CP0_COMPARE, 32'h0);
`endif

    // Asynchronous reset mid-run clears state without a clock edge
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    a1 = CP0_SR;
    expect_sig("async_sr", 0, 32'h0);
    expect_sig("async_epc", 1, 32'h0);
    expect_sig("async_int_req", 2, 32'h0);
    expect_sig("async_take", 3, 32'h0);
    tick();
    read_reg("async_prid", CP0_PRID, 32'h0000_7C01);
    read_reg("async_cause", CP0_CAUSE, 32'h0);
    reset_n = 1'b1;

`ifdef CP0_TIMER_EN
    begin
      bit fired;
      fired = 1'b0;
      mtc0(CP0_COMPARE, 32'd20);
      mtc0(CP0_SR, 32'h0000_8001);
      for (int i = 0; i < 100 && !fired; i++) begin
        @(negedge clk);
        if (take) fired = 1'b1;
        else begin
          @(posedge clk);
          #1;
        end
      end
      checks++;
      if (!fired) begin
        errors++;
        $display("FAIL timer_take: got no take expected take within 100 cycles");
      end else begin
        $display("ok   timer_take");
      end
      tick();
      read_reg("timer_cause_ip", CP0_CAUSE, 32'h0000_8000);
      read_reg("timer_compare_rd", CP0_COMPARE, 32'd20);
      mtc0(CP0_COMPARE, 32'hFFFF_FFFF);
      read_reg("timer_ack", CP0_CAUSE, 32'h0);
    end
`endif

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) tick();
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
